acc_drain: RTL
==============

Name: acc_drain

Overview:
- Read-side sequencer for the per-column accumulator queues at the bottom of the systolic array.
- Issues one-cycle dequeue pulses (the accumulator's acc_valid_in) and captures the returned words one cycle later.
- Serialises the words, with row-major addresses, onto a valid/ready stream toward the unified buffer.
- Uses credit-based flow control, because the accumulator's dequeue path cannot stall.

Parameters:
- NUM_COLS, 2, number of accumulator columns drained.
- DATA_W, 16, signed word width.
- ADDR_W, 8, unified-buffer address width.
- ROW_W, 8, width of the row-count input.
- FIFO_DEPTH, 4, capture FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- start  in  1  one-cycle pulse to begin a drain; sampled only in IDLE.
- base_addr  in  ADDR_W  destination base address, latched on start.
- num_rows  in  ROW_W  entries per column, latched on start.
- deq_req  out  NUM_COLS  per-column dequeue pulse, drives acc_valid_in.
- acc_valid  in  NUM_COLS  per-column acc_valid_out.
- acc_data  in  NUM_COLS x DATA_W  per-column acc_data_out.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DATA_W  stream word.
- out_addr  out  ADDR_W  stream address.
- busy  out  1  high from the cycle after an accepted start until the done cycle inclusive.
- done  out  1  one-cycle pulse when the drain is complete.
- err_underrun  out  1  sticky; cleared by the next accepted start.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM=IDLE, FIFO empty, counters 0, err_underrun 0.
- FSM states: IDLE, ISSUE, FLUSH, DONE.
  - IDLE: start=1 latches base_addr/num_rows, clears err_underrun, sets col=0, row=0. Next state is ISSUE, or DONE if num_rows==0 (no deq_req is ever issued in that case).
  - ISSUE: issues deq_req[col]=1 for one cycle when credit is available. After row reaches num_rows-1, col increments and row returns to 0. The last issue moves the FSM to FLUSH.
  - FLUSH: waits until nothing is in flight and the FIFO is empty, then moves to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Drain order is column-major; at most one deq_req bit is high per cycle; back-to-back issues are allowed.
- Credit rule: issue only when fifo_count + inflight < FIFO_DEPTH. inflight is 0 or 1 and equals "issued last cycle". A same-cycle FIFO pop counts as freeing an entry.
- Capture:
  - In the cycle after deq_req[c], sample acc_valid[c] and acc_data[c].
  - acc_valid level is ignored in every other cycle; the accumulator holds acc_valid_out high between dequeues.
  - If sampled acc_valid[c]=1: push {data, addr} with addr = base_addr + row*NUM_COLS + c, computed mod 2^ADDR_W.
  - If sampled acc_valid[c]=0: no push, err_underrun<=1, and the element is skipped. The drain still completes with done.
- Stream output:
  - out_valid = FIFO non-empty; out_data/out_addr = FIFO head.
  - Pop on out_valid && out_ready.
  - out_data/out_addr hold stable while out_valid=1 and out_ready=0.
- Timing:
  - Latency from deq_req to out_valid is 2 cycles when the FIFO was empty: capture cycle, then registered FIFO head.
  - Sustained throughput is 1 word/cycle with out_ready=1.
- Simultaneous events:
  - FIFO push and pop in the same cycle leaves the count unchanged.
  - start while busy is ignored.
  - out_ready toggling does not affect the issue order.
- Reset mid-operation: returns to IDLE immediately; the FIFO is flushed and no done is produced. The accumulators are expected to be reset in the same cycle.

Decomposition:
- Shared package tpu_pkg:
  - DATA_W and ADDR_W constants.
  - drain_state_t enum {IDLE, ISSUE, FLUSH, DONE}.
  - Typedef drain_word_t = struct {logic signed [DATA_W-1:0] data; logic [ADDR_W-1:0] addr;}.
- One sub-module: drain_fifo, a synchronous FIFO of drain_word_t, depth FIFO_DEPTH, with push/pop/count and an async active-low reset.

Test Plan:
- Basic drain: NUM_COLS=2, num_rows=2, base_addr=0x10, col0 returns {5,-3}, col1 returns {7,9}, out_ready=1.
  - -> deq_req order: col0, col0, col1, col1.
  - -> Stream (addr:data): 0x10:5, 0x12:-3, 0x11:7, 0x13:9.
  - -> done pulses once; err_underrun=0.
- Backpressure: same setup, out_ready=0 for 10 cycles, then 1.
  - -> No more than FIFO_DEPTH=4 deq_req pulses are issued while stalled.
  - -> out_data/out_addr stay stable while stalled; all 4 words arrive in order with no loss.
- Zero rows: start with num_rows=0.
  - -> No deq_req; done asserted 1 cycle after start; busy high only for that cycle.
- Underrun: col1 holds acc_valid=0 on its first capture.
  - -> 3 words emitted; err_underrun=1 after that capture; done still pulses.
  - -> A subsequent start clears err_underrun.
- Address wrap: base_addr=0xFE, num_rows=2, NUM_COLS=2.
  - -> Addresses 0xFE, 0x00, 0xFF, 0x01.
- Reset mid-drain: assert rst=0 asynchronously after 2 deq_req pulses.
  - -> All outputs 0 immediately, without waiting for a clock edge.
  - -> After release, FSM is in IDLE and a new start completes a normal drain.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic-array accumulator drain path.
package tpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} drain_state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] data;
        logic [ADDR_W-1:0]        addr;
    } drain_word_t;

    // Row-major destination address; wraps modulo 2^ADDR_W by truncation.
    function automatic logic [ADDR_W-1:0] drain_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] row,
        input logic [ADDR_W-1:0] col,
        input logic [ADDR_W-1:0] ncols
    );
        return base + row * ncols + col;
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Capture FIFO between the accumulator read port and the output stream.
// The head entry is read straight from registered storage.
module drain_fifo
    import tpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  drain_word_t                   i_wdata,
    input  logic                          i_pop,
    output drain_word_t                   o_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    drain_word_t        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/acc_drain.sv
// Drains the per-column accumulator queues column-major onto a valid/ready
// stream, using credits so a dequeued word always has a FIFO slot waiting.
module acc_drain
    import tpu_pkg::*;
#(
    parameter int NUM_COLS   = 2,
    parameter int ROW_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [ROW_W-1:0]           num_rows,
    output logic [NUM_COLS-1:0]        deq_req,
    input  logic [NUM_COLS-1:0]        acc_valid,
    input  logic [NUM_COLS*DATA_W-1:0] acc_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       err_underrun
);

    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    drain_state_t       r_state;
    drain_state_t       w_next;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [ROW_W-1:0]   r_rows;
    logic [ADDR_W-1:0]  r_base;
    logic               r_err;
    logic               r_vld_p1;
    logic [COL_W-1:0]   r_col_p1;
    logic [ADDR_W-1:0]  r_addr_p1;

    logic               w_start;
    logic               w_issue;
    logic               w_credit;
    logic               w_last_row;
    logic               w_last_col;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W:0]     w_used;
    drain_word_t        w_wdata;
    drain_word_t        w_head;

    assign w_start    = (r_state == IDLE) && start;
    assign w_last_row = (r_row == r_rows - ROW_W'(1));
    assign w_last_col = (r_col == COL_W'(NUM_COLS - 1));
    assign out_valid  = (w_count != '0);
    assign w_pop      = out_valid && out_ready;
    // The word still in flight holds a slot even if it turns out to be an underrun.
    assign w_used     = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_vld_p1) - (CNT_W+1)'(w_pop);
    assign w_credit   = (w_used < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        deq_req = '0;
        case (r_state)
            IDLE: begin
                if (start) w_next = (num_rows == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (w_credit) begin
                    w_issue        = 1'b1;
                    deq_req[r_col] = 1'b1;
                    if (w_last_row && w_last_col) w_next = FLUSH;
                end
            end
            FLUSH: begin
                if (!r_vld_p1 && (w_count == '0)) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_col    <= '0;
            r_row    <= '0;
            r_vld_p1 <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_vld_p1 <= w_issue;
            if (r_vld_p1 && !acc_valid[r_col_p1]) r_err <= 1'b1;
            if (w_issue) begin
                if (w_last_row) begin
                    r_row <= '0;
                    r_col <= r_col + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end
            if (w_start) begin
                r_col <= '0;
                r_row <= '0;
                r_err <= 1'b0;
            end
        end
    end

    // ---- issue stage -> capture stage (_p1) ----
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_base <= base_addr;
            r_rows <= num_rows;
        end
        if (w_issue) begin
            r_col_p1  <= r_col;
            r_addr_p1 <= drain_addr(r_base, ADDR_W'(r_row), ADDR_W'(r_col), ADDR_W'(NUM_COLS));
        end
    end

    assign w_push       = r_vld_p1 && acc_valid[r_col_p1];
    assign w_wdata.data = acc_data[r_col_p1*DATA_W +: DATA_W];
    assign w_wdata.addr = r_addr_p1;

    drain_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    // Head storage is not reset, so gate it to keep the stream at zero when idle.
    assign out_data     = out_valid ? w_head.data : '0;
    assign out_addr     = out_valid ? w_head.addr : '0;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign err_underrun = r_err;

endmodule
